// File: rtl/iter_muldiv_if.sv
// Start/busy/done handshake and operand/result bundle
// for the iterative multiply/divide unit.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/iter_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: shift-add multiplier,
// restoring divider, results held in HI/LO.
module iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic         clk,
  input logic         rst,
  iter_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic               neg_res;
  logic               neg_rem;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_q;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     m_sum;
  logic [WIDTH:0]     d_sh;
  logic [WIDTH:0]     d_diff;
  logic               d_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_dz;

  assign sgn   = ~bus.op[0];
  assign a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply: acc = {product_hi, multiplier}; divide: acc = {rem, quo}
  assign m_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
  assign d_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign d_diff = d_sh - {1'b0, opd};
  assign d_ge   = d_sh >= {1'b0, opd};

  always_comb begin
    acc_step = {m_sum, acc[WIDTH-1:1]};
    if (op_q[1]) begin
      if (d_ge)
        acc_step = {d_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {d_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    res_dz = 1'b0;
    if (op_q[1]) begin
      if (opd == '0) begin
        res_hi = a_raw;
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        if (neg_res) res_lo = -acc[WIDTH-1:0];
        if (neg_rem) res_hi = -acc[2*WIDTH-1:WIDTH];
      end
    end else if (neg_res) begin
      {res_hi, res_lo} = -acc;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1))
          state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      opd     <= '0;
      a_raw   <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            op_q    <= bus.op;
            a_raw   <= bus.a;
            neg_res <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem <= sgn & bus.a[WIDTH-1];
            opd     <= bus.op[1] ? b_mag : a_mag;
            acc     <= {{WIDTH{1'b0}},
                        (bus.op[1] ? a_mag : b_mag)};
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          dz_q   <= res_dz;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Bench for iter_muldiv at WIDTH=32 and WIDTH=8: cycle scoreboard
// against an arithmetic model plus directed literal checks.
module tb_iter_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_muldiv_if #(.WIDTH(32)) b32 ();
  iter_muldiv_if #(.WIDTH(8))  b8 ();

  iter_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.slave)
  );
  iter_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave)
  );

  logic        st [2];
  logic [1:0]  opv [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];

  assign b32.start = st[0];
  assign b32.op    = opv[0];
  assign b32.a     = av[0];
  assign b32.b     = bv[0];
  assign b8.start  = st[1];
  assign b8.op     = opv[1];
  assign b8.a      = av[1][7:0];
  assign b8.b      = bv[1][7:0];

  logic        o_busy [2];
  logic        o_done [2];
  logic        o_dz [2];
  logic [31:0] o_hi [2];
  logic [31:0] o_lo [2];

  assign o_busy[0] = b32.busy;
  assign o_done[0] = b32.done;
  assign o_dz[0]   = b32.div_zero;
  assign o_hi[0]   = b32.hi;
  assign o_lo[0]   = b32.lo;
  assign o_busy[1] = b8.busy;
  assign o_done[1] = b8.done;
  assign o_dz[1]   = b8.div_zero;
  assign o_hi[1]   = {24'h0, b8.hi};
  assign o_lo[1]   = {24'h0, b8.lo};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result as {div_zero, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int w);
    logic [63:0] m, ua, ub, p, q, r;
    longint sa, sb;
    m  = {64{1'b1}} >> (64 - w);
    ua = {32'h0, a} & m;
    ub = {32'h0, b} & m;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w)
                 : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w)
                 : longint'(ub);
    if (!op[1]) begin
      p = op[0] ? ua * ub : 64'(sa * sb);
      return {1'b0, 32'((p >> w) & m), 32'(p & m)};
    end
    if (ub == 0)
      return {1'b1, 32'(ua), 32'(m)};
    if (op[0]) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end
    return {1'b0, 32'(r & m), 32'(q & m)};
  endfunction

  int          e = 0;
  int          t0 [2];
  logic        pend [2];
  int          due [2];
  logic [64:0] res [2];
  logic [64:0] m_out [2];
  logic        m_busy [2];
  logic        m_done [2];

  task automatic model_edge(input int k);
    int   w;
    logic was;
    w   = (k == 0) ? 32 : 8;
    was = pend[k];
    m_done[k] = 1'b0;
    if (pend[k] && e == due[k]) begin
      m_out[k]  = res[k];
      m_done[k] = 1'b1;
      pend[k]   = 1'b0;
    end
    if (!was && st[k]) begin
      pend[k] = 1'b1;
      due[k]  = e + w + 1;
      res[k]  = model(opv[k], av[k], bv[k], w);
    end
    m_busy[k] = pend[k];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        pend[k]   = 1'b0;
        due[k]    = 0;
        res[k]    = '0;
        m_out[k]  = '0;
        m_busy[k] = 1'b0;
        m_done[k] = 1'b0;
      end
    end else begin
      e++;
      model_edge(0);
      model_edge(1);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("handshake%0d", k),
          65'({o_busy[k], o_done[k]}),
          65'({m_busy[k], m_done[k]}));
      chk($sformatf("result%0d", k),
          {o_dz[k], o_hi[k], o_lo[k]}, m_out[k]);
    end
  end

  task automatic issue(input int k, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    st[k]  = 1'b1;
    opv[k] = op;
    av[k]  = a;
    bv[k]  = b;
    @(negedge clk);
    t0[k]  = e;
    st[k]  = 1'b0;
    opv[k] = 2'($urandom);
    av[k]  = $urandom;
    bv[k]  = $urandom;
  endtask

  task automatic wait_done(input int k, input logic [31:0] ehi,
                           input logic [31:0] elo, input logic edz);
    int w;
    w = (k == 0) ? 32 : 8;
    while (!o_done[k] && (e - t0[k]) < 100) @(negedge clk);
    chk("latency", 65'(e - t0[k]), 65'(w + 1));
    chk("hi", 65'(o_hi[k]), 65'(ehi));
    chk("lo", 65'(o_lo[k]), 65'(elo));
    chk("div_zero", 65'(o_dz[k]), 65'(edz));
  endtask

  task automatic run(input int k, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz);
    @(negedge clk);
    issue(k, op, a, b);
    wait_done(k, ehi, elo, edz);
  endtask

  initial begin
    int nd;
    for (int k = 0; k < 2; k++) begin
      st[k]  = 1'b0;
      opv[k] = '0;
      av[k]  = '0;
      bv[k]  = '0;
      t0[k]  = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("model_multu",
        model(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32),
        {1'b0, 32'hFFFFFFFE, 32'h00000001});
    chk("model_div_min",
        model(2'd2, 32'h80000000, 32'hFFFFFFFF, 32),
        {1'b0, 32'h0, 32'h80000000});
    chk("model_div_neg",
        model(2'd2, 32'hFFFFFFF9, 32'd2, 32),
        {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("model_w8",
        model(2'd1, 32'hFF, 32'hFF, 8),
        {1'b0, 32'hFE, 32'h01});

    run(0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001, 1'b0);

    // Abandon MULTU 7*9 mid-run
    @(negedge clk);
    issue(0, 2'd1, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 65'(o_busy[0]), 65'd0);
    chk("rst_hi", 65'(o_hi[0]), 65'd0);
    chk("rst_lo", 65'(o_lo[0]), 65'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_done[0]) nd++;
    end
    chk("no_done_after_rst", 65'(nd), 65'd0);

    run(0, 2'd0, 32'hFFFFFFF9, 32'd3,
        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run(0, 2'd2, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(0, 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run(0, 2'd3, 32'h1234, 32'd0,
        32'h1234, 32'hFFFFFFFF, 1'b1);
    run(0, 2'd2, 32'h80000000, 32'hFFFFFFFF,
        32'h0, 32'h80000000, 1'b0);
    run(0, 2'd2, 32'd7, 32'hFFFFFFFE,
        32'd1, 32'hFFFFFFFD, 1'b0);

    // Start pulsed while busy must be dropped
    @(negedge clk);
    issue(0, 2'd1, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    st[0]  = 1'b1;
    opv[0] = 2'd0;
    av[0]  = 32'd5;
    bv[0]  = 32'd5;
    @(negedge clk);
    st[0]  = 1'b0;
    wait_done(0, 32'd0, 32'd63, 1'b0);

    // Back-to-back: start in the done cycle
    @(negedge clk);
    issue(0, 2'd3, 32'd100, 32'd7);
    wait_done(0, 32'd2, 32'd14, 1'b0);
    issue(0, 2'd1, 32'd6, 32'd7);
    wait_done(0, 32'd0, 32'd42, 1'b0);

    run(1, 2'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
    run(1, 2'd0, 32'hF9, 32'h03, 32'hFF, 32'hEB, 1'b0);
    run(1, 2'd2, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0);
    run(1, 2'd3, 32'h5A, 32'h00, 32'h5A, 32'hFF, 1'b1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
